// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control path: opcodes, ALUOp,
// datapath mux selects, FSM state encodings and the packed control word.
package mips_ctrl_pkg;

    localparam int STATE_BITS = 4;
    localparam int ALUOP_BITS = 3;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    // ALUOp encodings are also decoded by the ALU control unit.
    localparam logic [ALUOP_BITS-1:0] ALUOP_ADD   = 3'b000;
    localparam logic [ALUOP_BITS-1:0] ALUOP_SUB   = 3'b001;
    localparam logic [ALUOP_BITS-1:0] ALUOP_RTYPE = 3'b010;
    localparam logic [ALUOP_BITS-1:0] ALUOP_AND   = 3'b100;
    localparam logic [ALUOP_BITS-1:0] ALUOP_OR    = 3'b101;

    localparam logic [1:0] SRCB_RT     = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;
    localparam logic [1:0] PCSRC_RS     = 2'b11;

    typedef enum logic [STATE_BITS-1:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEM_ADDR = 4'd2,
        S_MEM_RD   = 4'd3,
        S_MEM_WB   = 4'd4,
        S_MEM_WR   = 4'd5,
        S_R_EXEC   = 4'd6,
        S_R_WB     = 4'd7,
        S_BRANCH   = 4'd8,
        S_JUMP     = 4'd9,
        S_I_EXEC   = 4'd10,
        S_I_WB     = 4'd11
    } state_t;

    typedef struct packed {
        logic                  pc_write;
        logic                  pc_write_cond;
        logic                  i_or_d;
        logic                  mem_read;
        logic                  mem_write;
        logic                  ir_write;
        logic                  mem_to_reg;
        logic                  reg_dst;
        logic                  reg_write;
        logic                  alu_src_a;
        logic [1:0]            alu_src_b;
        logic [1:0]            pc_source;
        logic [ALUOP_BITS-1:0] alu_op;
        logic                  illegal_op;
    } ctrl_t;

    function automatic logic is_legal_op(input logic [5:0] op);
        case (op)
            OP_RTYPE, OP_J, OP_BEQ, OP_ADDI, OP_ANDI, OP_ORI, OP_LW, OP_SW:
                is_legal_op = 1'b1;
            default:
                is_legal_op = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_out_decode.sv
// Purely combinational decode of FSM state (plus opcode/mem_ready/jr) into
// the datapath control word; everything is forced low while reset is high.
module multicycle_out_decode
    import mips_ctrl_pkg::*;
(
    input  logic                  reset,
    input  logic [STATE_BITS-1:0] state,
    input  logic [5:0]            opcode,
    input  logic                  mem_ready,
    input  logic                  jr,
    output ctrl_t                 ctrl
);

    always_comb begin
        ctrl = '0;
        if (!reset) begin
            case (state)
                S_FETCH: begin
                    ctrl.mem_read  = 1'b1;
                    ctrl.alu_src_b = SRCB_FOUR;
                    ctrl.alu_op    = ALUOP_ADD;
                    ctrl.pc_source = PCSRC_ALU;
                    ctrl.ir_write  = mem_ready;
                    ctrl.pc_write  = mem_ready;
                end
                S_DECODE: begin
                    ctrl.alu_src_b  = SRCB_IMM_SH;
                    ctrl.alu_op     = ALUOP_ADD;
                    ctrl.illegal_op = !is_legal_op(opcode);
                end
                S_MEM_ADDR: begin
                    ctrl.alu_src_a = 1'b1;
                    ctrl.alu_src_b = SRCB_IMM;
                    ctrl.alu_op    = ALUOP_ADD;
                end
                S_MEM_RD: begin
                    ctrl.mem_read = 1'b1;
                    ctrl.i_or_d   = 1'b1;
                end
                S_MEM_WB: begin
                    ctrl.reg_write  = 1'b1;
                    ctrl.mem_to_reg = 1'b1;
                end
                S_MEM_WR: begin
                    ctrl.mem_write = 1'b1;
                    ctrl.i_or_d    = 1'b1;
                end
                // jr is resolved here: the PC is loaded from rs and writeback is skipped.
                S_R_EXEC: begin
                    ctrl.alu_src_a = 1'b1;
                    ctrl.alu_src_b = SRCB_RT;
                    ctrl.alu_op    = ALUOP_RTYPE;
                    if (jr) begin
                        ctrl.pc_write  = 1'b1;
                        ctrl.pc_source = PCSRC_RS;
                    end
                end
                S_R_WB: begin
                    ctrl.reg_write = 1'b1;
                    ctrl.reg_dst   = 1'b1;
                end
                S_BRANCH: begin
                    ctrl.alu_src_a     = 1'b1;
                    ctrl.alu_src_b     = SRCB_RT;
                    ctrl.alu_op        = ALUOP_SUB;
                    ctrl.pc_write_cond = 1'b1;
                    ctrl.pc_source     = PCSRC_ALUOUT;
                end
                S_JUMP: begin
                    ctrl.pc_write  = 1'b1;
                    ctrl.pc_source = PCSRC_JUMP;
                end
                S_I_EXEC: begin
                    ctrl.alu_src_a = 1'b1;
                    ctrl.alu_src_b = SRCB_IMM;
                    case (opcode)
                        OP_ANDI: ctrl.alu_op = ALUOP_AND;
                        OP_ORI:  ctrl.alu_op = ALUOP_OR;
                        default: ctrl.alu_op = ALUOP_ADD;
                    endcase
                end
                S_I_WB: begin
                    ctrl.reg_write = 1'b1;
                end
                default: ctrl = '0;
            endcase
        end
    end

endmodule

// File: rtl/multicycle_control.sv
// Main control FSM of the multi-cycle MIPS datapath: holds the state register
// and next-state logic; control outputs come from multicycle_out_decode.
module multicycle_control
    import mips_ctrl_pkg::*;
#(
    parameter int STATE_W = 4,
    parameter int ALUOP_W = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [5:0]         opcode,
    input  logic               jr,
    input  logic               mem_ready,
    output logic               PCWrite,
    output logic               PCWriteCond,
    output logic               IorD,
    output logic               MemRead,
    output logic               MemWrite,
    output logic               IRWrite,
    output logic               MemtoReg,
    output logic               RegDst,
    output logic               RegWrite,
    output logic               ALUSrcA,
    output logic [1:0]         ALUSrcB,
    output logic [1:0]         PCSource,
    output logic [ALUOP_W-1:0] ALUOp,
    output logic [STATE_W-1:0] state,
    output logic               illegal_op
);

    state_t state_q;
    state_t state_next;
    ctrl_t  ctrl;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_next;
        end
    end

    // Unreachable encodings fall through to the default and recover to FETCH.
    always_comb begin
        state_next = S_FETCH;
        case (state_q)
            S_FETCH:    state_next = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (opcode)
                    OP_RTYPE:              state_next = S_R_EXEC;
                    OP_LW, OP_SW:          state_next = S_MEM_ADDR;
                    OP_BEQ:                state_next = S_BRANCH;
                    OP_J:                  state_next = S_JUMP;
                    OP_ADDI, OP_ANDI,
                    OP_ORI:                state_next = S_I_EXEC;
                    default:               state_next = S_FETCH;
                endcase
            end
            S_MEM_ADDR: state_next = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD:   state_next = mem_ready ? S_MEM_WB : S_MEM_RD;
            S_MEM_WB:   state_next = S_FETCH;
            S_MEM_WR:   state_next = mem_ready ? S_FETCH : S_MEM_WR;
            S_R_EXEC:   state_next = jr ? S_FETCH : S_R_WB;
            S_R_WB:     state_next = S_FETCH;
            S_BRANCH:   state_next = S_FETCH;
            S_JUMP:     state_next = S_FETCH;
            S_I_EXEC:   state_next = S_I_WB;
            S_I_WB:     state_next = S_FETCH;
            default:    state_next = S_FETCH;
        endcase
    end

    multicycle_out_decode u_out_decode (
        .reset     (reset),
        .state     (state_q),
        .opcode    (opcode),
        .mem_ready (mem_ready),
        .jr        (jr),
        .ctrl      (ctrl)
    );

    assign PCWrite     = ctrl.pc_write;
    assign PCWriteCond = ctrl.pc_write_cond;
    assign IorD        = ctrl.i_or_d;
    assign MemRead     = ctrl.mem_read;
    assign MemWrite    = ctrl.mem_write;
    assign IRWrite     = ctrl.ir_write;
    assign MemtoReg    = ctrl.mem_to_reg;
    assign RegDst      = ctrl.reg_dst;
    assign RegWrite    = ctrl.reg_write;
    assign ALUSrcA     = ctrl.alu_src_a;
    assign ALUSrcB     = ctrl.alu_src_b;
    assign PCSource    = ctrl.pc_source;
    assign ALUOp       = ctrl.alu_op;
    assign illegal_op  = ctrl.illegal_op;
    assign state       = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: walks each instruction class through
// the FSM and compares state plus the full control word every cycle.
module tb_multicycle_control;
    import mips_ctrl_pkg::*;

    logic       clk;
    logic       reset;
    logic [5:0] opcode;
    logic       jr;
    logic       mem_ready;
    logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
    logic       MemtoReg, RegDst, RegWrite, ALUSrcA;
    logic [1:0] ALUSrcB, PCSource;
    logic [2:0] ALUOp;
    logic [3:0] state;
    logic       illegal_op;

    int checks = 0;
    int errors = 0;

    // Word order: pcw,pcwc,iord,mrd,mwr,irw,m2r,rdst,rw,srca,srcb[2],pcsrc[2],aluop[3],illegal
    localparam logic [18:0] CW_ZERO      = 19'b0_0_0_0_0_0_0_0_0_0_00_00_000_0;
    localparam logic [18:0] CW_FETCH_W   = 19'b0_0_0_1_0_0_0_0_0_0_01_00_000_0;
    localparam logic [18:0] CW_FETCH_R   = 19'b1_0_0_1_0_1_0_0_0_0_01_00_000_0;
    localparam logic [18:0] CW_DECODE    = 19'b0_0_0_0_0_0_0_0_0_0_11_00_000_0;
    localparam logic [18:0] CW_DECODE_IL = 19'b0_0_0_0_0_0_0_0_0_0_11_00_000_1;
    localparam logic [18:0] CW_MEM_ADDR  = 19'b0_0_0_0_0_0_0_0_0_1_10_00_000_0;
    localparam logic [18:0] CW_MEM_RD    = 19'b0_0_1_1_0_0_0_0_0_0_00_00_000_0;
    localparam logic [18:0] CW_MEM_WB    = 19'b0_0_0_0_0_0_1_0_1_0_00_00_000_0;
    localparam logic [18:0] CW_MEM_WR    = 19'b0_0_1_0_1_0_0_0_0_0_00_00_000_0;
    localparam logic [18:0] CW_R_EXEC    = 19'b0_0_0_0_0_0_0_0_0_1_00_00_010_0;
    localparam logic [18:0] CW_R_EXEC_JR = 19'b1_0_0_0_0_0_0_0_0_1_00_11_010_0;
    localparam logic [18:0] CW_R_WB      = 19'b0_0_0_0_0_0_0_1_1_0_00_00_000_0;
    localparam logic [18:0] CW_BRANCH    = 19'b0_1_0_0_0_0_0_0_0_1_00_01_001_0;
    localparam logic [18:0] CW_JUMP      = 19'b1_0_0_0_0_0_0_0_0_0_00_10_000_0;
    localparam logic [18:0] CW_I_ADDI    = 19'b0_0_0_0_0_0_0_0_0_1_10_00_000_0;
    localparam logic [18:0] CW_I_ANDI    = 19'b0_0_0_0_0_0_0_0_0_1_10_00_100_0;
    localparam logic [18:0] CW_I_ORI     = 19'b0_0_0_0_0_0_0_0_0_1_10_00_101_0;
    localparam logic [18:0] CW_I_WB      = 19'b0_0_0_0_0_0_0_0_1_0_00_00_000_0;

    localparam logic [5:0] OP_BAD = 6'b111111;

    logic [18:0] observed_cw;
    assign observed_cw = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
                          MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, PCSource,
                          ALUOp, illegal_op};

    multicycle_control #(.STATE_W(4), .ALUOP_W(3)) dut (
        .clk        (clk),
        .reset      (reset),
        .opcode     (opcode),
        .jr         (jr),
        .mem_ready  (mem_ready),
        .PCWrite    (PCWrite),
        .PCWriteCond(PCWriteCond),
        .IorD       (IorD),
        .MemRead    (MemRead),
        .MemWrite   (MemWrite),
        .IRWrite    (IRWrite),
        .MemtoReg   (MemtoReg),
        .RegDst     (RegDst),
        .RegWrite   (RegWrite),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .PCSource   (PCSource),
        .ALUOp      (ALUOp),
        .state      (state),
        .illegal_op (illegal_op)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic applyStimulus(input logic [5:0] op, input logic ready, input logic jump_reg);
        opcode    = op;
        mem_ready = ready;
        jr        = jump_reg;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [3:0] exp_state, input logic [18:0] exp_cw);
        checks++;
        assert (state === exp_state) else begin
            errors++;
            $error("[TB] FAIL %s state: observed=%0d expected=%0d", tag, state, exp_state);
        end
        checks++;
        assert (observed_cw === exp_cw) else begin
            errors++;
            $error("[TB] FAIL %s ctrl: observed=%b expected=%b", tag, observed_cw, exp_cw);
        end
    endtask

    // One clock per step: advance past the edge, drive inputs, then compare.
    task automatic step(input string tag, input logic [5:0] op, input logic ready,
                        input logic jump_reg, input logic [3:0] exp_state, input logic [18:0] exp_cw);
        @(posedge clk);
        #1;
        applyStimulus(op, ready, jump_reg);
        checkOutput(tag, exp_state, exp_cw);
    endtask

    initial begin
        reset = 1'b1;
        applyStimulus(OP_LW, 1'b1, 1'b0);
        checkOutput("reset_hold", S_FETCH, CW_ZERO);

        @(posedge clk);
        #1;
        reset = 1'b0;
        applyStimulus(OP_LW, 1'b1, 1'b0);
        checkOutput("lw_fetch", S_FETCH, CW_FETCH_R);
        step("lw_decode",  OP_LW, 1'b1, 1'b0, S_DECODE,   CW_DECODE);
        step("lw_addr",    OP_LW, 1'b1, 1'b0, S_MEM_ADDR, CW_MEM_ADDR);
        step("lw_rd",      OP_LW, 1'b1, 1'b0, S_MEM_RD,   CW_MEM_RD);
        step("lw_wb",      OP_LW, 1'b1, 1'b0, S_MEM_WB,   CW_MEM_WB);

        step("fetch_wait0", OP_RTYPE, 1'b0, 1'b0, S_FETCH, CW_FETCH_W);
        step("fetch_wait1", OP_RTYPE, 1'b0, 1'b0, S_FETCH, CW_FETCH_W);
        step("fetch_wait2", OP_RTYPE, 1'b0, 1'b0, S_FETCH, CW_FETCH_W);
        step("fetch_rdy",   OP_RTYPE, 1'b1, 1'b0, S_FETCH, CW_FETCH_R);
        step("jr_decode",   OP_RTYPE, 1'b1, 1'b0, S_DECODE, CW_DECODE);
        step("jr_exec",     OP_RTYPE, 1'b1, 1'b1, S_R_EXEC, CW_R_EXEC_JR);

        step("ori_fetch",  OP_ORI, 1'b1, 1'b0, S_FETCH,  CW_FETCH_R);
        step("ori_decode", OP_ORI, 1'b1, 1'b0, S_DECODE, CW_DECODE);
        step("ori_exec",   OP_ORI, 1'b1, 1'b0, S_I_EXEC, CW_I_ORI);
        step("ori_wb",     OP_ORI, 1'b1, 1'b0, S_I_WB,   CW_I_WB);
        step("andi_fetch",  OP_ANDI, 1'b1, 1'b0, S_FETCH,  CW_FETCH_R);
        step("andi_decode", OP_ANDI, 1'b1, 1'b0, S_DECODE, CW_DECODE);
        step("andi_exec",   OP_ANDI, 1'b1, 1'b0, S_I_EXEC, CW_I_ANDI);
        step("andi_wb",     OP_ANDI, 1'b1, 1'b0, S_I_WB,   CW_I_WB);
        step("addi_fetch",  OP_ADDI, 1'b1, 1'b0, S_FETCH,  CW_FETCH_R);
        step("addi_decode", OP_ADDI, 1'b1, 1'b0, S_DECODE, CW_DECODE);
        step("addi_exec",   OP_ADDI, 1'b1, 1'b0, S_I_EXEC, CW_I_ADDI);
        step("addi_wb",     OP_ADDI, 1'b1, 1'b0, S_I_WB,   CW_I_WB);

        step("r_fetch",  OP_RTYPE, 1'b1, 1'b0, S_FETCH,  CW_FETCH_R);
        step("r_decode", OP_RTYPE, 1'b1, 1'b0, S_DECODE, CW_DECODE);
        step("r_exec",   OP_RTYPE, 1'b1, 1'b0, S_R_EXEC, CW_R_EXEC);
        step("r_wb",     OP_RTYPE, 1'b1, 1'b0, S_R_WB,   CW_R_WB);

        step("beq_fetch",  OP_BEQ, 1'b1, 1'b0, S_FETCH,  CW_FETCH_R);
        step("beq_decode", OP_BEQ, 1'b1, 1'b0, S_DECODE, CW_DECODE);
        step("beq_exec",   OP_BEQ, 1'b1, 1'b0, S_BRANCH, CW_BRANCH);
        step("j_fetch",    OP_J,   1'b1, 1'b0, S_FETCH,  CW_FETCH_R);
        step("j_decode",   OP_J,   1'b1, 1'b0, S_DECODE, CW_DECODE);
        step("j_exec",     OP_J,   1'b1, 1'b0, S_JUMP,   CW_JUMP);

        step("bad_fetch",  OP_BAD, 1'b1, 1'b0, S_FETCH,  CW_FETCH_R);
        step("bad_decode", OP_BAD, 1'b1, 1'b0, S_DECODE, CW_DECODE_IL);
        step("bad_return", OP_BAD, 1'b0, 1'b0, S_FETCH,  CW_FETCH_W);

        step("lww_fetch",  OP_LW, 1'b1, 1'b0, S_FETCH,    CW_FETCH_R);
        step("lww_decode", OP_LW, 1'b0, 1'b0, S_DECODE,   CW_DECODE);
        step("lww_addr",   OP_LW, 1'b0, 1'b0, S_MEM_ADDR, CW_MEM_ADDR);
        step("lww_rd0",    OP_LW, 1'b0, 1'b0, S_MEM_RD,   CW_MEM_RD);
        step("lww_rd1",    OP_LW, 1'b1, 1'b0, S_MEM_RD,   CW_MEM_RD);
        step("lww_wb",     OP_LW, 1'b1, 1'b0, S_MEM_WB,   CW_MEM_WB);

        step("sw_fetch",  OP_SW, 1'b1, 1'b0, S_FETCH,    CW_FETCH_R);
        step("sw_decode", OP_SW, 1'b0, 1'b0, S_DECODE,   CW_DECODE);
        step("sw_addr",   OP_SW, 1'b0, 1'b0, S_MEM_ADDR, CW_MEM_ADDR);
        step("sw_wr0",    OP_SW, 1'b0, 1'b0, S_MEM_WR,   CW_MEM_WR);
        step("sw_wr1",    OP_SW, 1'b0, 1'b0, S_MEM_WR,   CW_MEM_WR);

        reset = 1'b1;
        #1;
        checkOutput("sw_reset_now", S_FETCH, CW_ZERO);
        @(posedge clk);
        #1;
        checkOutput("sw_reset_hold", S_FETCH, CW_ZERO);
        reset = 1'b0;
        applyStimulus(OP_SW, 1'b0, 1'b0);
        checkOutput("sw_reset_rel", S_FETCH, CW_FETCH_W);
        step("post_rst_fetch",  OP_SW, 1'b1, 1'b0, S_FETCH,  CW_FETCH_R);
        step("post_rst_decode", OP_SW, 1'b0, 1'b0, S_DECODE, CW_DECODE);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
